// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
//   Holds the systolic-array program in an on-chip instruction memory and issues
//   one instruction at a time. Each issue is marked by a one-cycle
//   init_inst_pulse_o. The sequencer then waits for a rising edge on the array's
//   done flag before it moves on. LOOP/ENDL/JUMP/HALT opcodes are executed
//   internally and are never issued. A small loop stack provides nested
//   hardware loops.
//
// Ports
//   clk_i              clock, rising edge
//   reset_i            synchronous reset, active high
//   start_i            run from start_pc_i (accepted in IDLE/HALT only)
//   start_pc_i         entry address
//   flag_i             array done; its rising edge completes the issued instruction
//   force_inst_i       issue imem_wdata_i directly (IDLE only)
//   imem_wen_i         program-load write enable (IDLE/HALT only)
//   imem_waddr_i       program-load address
//   imem_wdata_i       program-load data / forced instruction
//   instruction_o      last issued instruction, held until the next issue
//   init_inst_pulse_o  one-cycle strobe marking a valid instruction_o
//   pc_o               program counter
//   busy_o             sequencer is neither IDLE nor HALT
//   halted_o           sequencer is in HALT
//   error_o            sticky loop-stack overflow/underflow indication
// -----------------------------------------------------------------------------
module inst_sequencer #(
    parameter int                     INST_BITS   = 128,
    parameter int                     OPCODE_BITS = 8,
    parameter int                     PC_DEPTH    = 1024,
    parameter int                     PC_BITS     = $clog2(PC_DEPTH),
    parameter int                     LOOP_DEPTH  = 4,
    parameter int                     CNT_BITS    = 16,
    parameter logic [OPCODE_BITS-1:0] OP_LOOP     = 8'hF0,
    parameter logic [OPCODE_BITS-1:0] OP_ENDL     = 8'hF1,
    parameter logic [OPCODE_BITS-1:0] OP_JUMP     = 8'hF2,
    parameter logic [OPCODE_BITS-1:0] OP_HALT     = 8'hFF,
    parameter string                  INIT_FILE   = ""
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [PC_BITS-1:0]   start_pc_i,
    input  logic                 flag_i,
    input  logic                 force_inst_i,
    input  logic                 imem_wen_i,
    input  logic [PC_BITS-1:0]   imem_waddr_i,
    input  logic [INST_BITS-1:0] imem_wdata_i,
    output logic [INST_BITS-1:0] instruction_o,
    output logic                 init_inst_pulse_o,
    output logic [PC_BITS-1:0]   pc_o,
    output logic                 busy_o,
    output logic                 halted_o,
    output logic                 error_o
);

    localparam int SP_BITS  = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_BITS = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam logic [SP_BITS-1:0] SP_FULL = SP_BITS'(LOOP_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_FWAIT  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [PC_BITS-1:0]   pc_q, pc_d;
    logic [INST_BITS-1:0] instr_q, instr_d;
    logic                 pulse_q, pulse_d;
    logic                 error_q, error_d;
    logic                 busy_q, halted_q;
    logic                 flag_q;
    logic [SP_BITS-1:0]   sp_q, sp_d;
    logic [PC_BITS-1:0]   lstart_q [LOOP_DEPTH];
    logic [PC_BITS-1:0]   lstart_d [LOOP_DEPTH];
    logic [CNT_BITS-1:0]  lcnt_q   [LOOP_DEPTH];
    logic [CNT_BITS-1:0]  lcnt_d   [LOOP_DEPTH];

    logic [INST_BITS-1:0] mem_q [PC_DEPTH];
    logic [INST_BITS-1:0] rdata_q;

    logic [OPCODE_BITS-1:0] opcode_s;
    logic [CNT_BITS-1:0]    count_s;
    logic [IDX_BITS-1:0]    push_idx_s;
    logic [IDX_BITS-1:0]    top_idx_s;
    logic                   flag_rise_s;
    logic                   mem_wr_en_s;

    assign opcode_s    = rdata_q[INST_BITS-1 -: OPCODE_BITS];
    assign count_s     = rdata_q[CNT_BITS-1:0];
    assign push_idx_s  = IDX_BITS'(sp_q);
    assign top_idx_s   = IDX_BITS'(sp_q - SP_BITS'(1));
    assign flag_rise_s = flag_i & ~flag_q;
    // Loading is only allowed while stopped, so a write never races a FETCH.
    assign mem_wr_en_s = imem_wen_i && ((state_q == S_IDLE) || (state_q == S_HALT));

    // Instruction memory: independent write port, registered read of mem[pc]; not reset.
    always_ff @(posedge clk_i) begin
        if (mem_wr_en_s) begin
            mem_q[imem_waddr_i] <= imem_wdata_i;
        end
        rdata_q <= mem_q[pc_q];
    end

    // Next-state, program counter, loop stack and issue logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pulse_d  = 1'b0;
        error_d  = error_q;
        sp_d     = sp_q;
        lstart_d = lstart_q;
        lcnt_d   = lcnt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    pc_d    = start_pc_i;
                    error_d = 1'b0;
                    sp_d    = SP_BITS'(0);
                    state_d = S_FETCH;
                end else if (force_inst_i && (state_q == S_IDLE)) begin
                    instr_d = imem_wdata_i;
                    pulse_d = 1'b1;
                    state_d = S_FWAIT;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_LOOP: begin
                        if (sp_q == SP_FULL) begin
                            error_d = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            // A zero count still runs the body once.
                            lstart_d[push_idx_s] = pc_q + PC_BITS'(1);
                            lcnt_d[push_idx_s]   = (count_s == CNT_BITS'(0)) ? CNT_BITS'(1) : count_s;
                            sp_d    = sp_q + SP_BITS'(1);
                            pc_d    = pc_q + PC_BITS'(1);
                            state_d = S_FETCH;
                        end
                    end
                    OP_ENDL: begin
                        if (sp_q == SP_BITS'(0)) begin
                            error_d = 1'b1;
                            state_d = S_HALT;
                        end else if (lcnt_q[top_idx_s] > CNT_BITS'(1)) begin
                            lcnt_d[top_idx_s] = lcnt_q[top_idx_s] - CNT_BITS'(1);
                            pc_d    = lstart_q[top_idx_s];
                            state_d = S_FETCH;
                        end else begin
                            sp_d    = sp_q - SP_BITS'(1);
                            pc_d    = pc_q + PC_BITS'(1);
                            state_d = S_FETCH;
                        end
                    end
                    OP_JUMP: begin
                        pc_d    = rdata_q[PC_BITS-1:0];
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        instr_d = rdata_q;
                        pulse_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                endcase
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flag_rise_s) begin
                    pc_d    = pc_q + PC_BITS'(1);
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FWAIT: begin
                if (flag_rise_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FWAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; busy/halted are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_BITS'(0);
            instr_q  <= INST_BITS'(0);
            pulse_q  <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            flag_q   <= 1'b0;
            sp_q     <= SP_BITS'(0);
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                lstart_q[i] <= PC_BITS'(0);
                lcnt_q[i]   <= CNT_BITS'(0);
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pulse_q  <= pulse_d;
            error_q  <= error_d;
            busy_q   <= (state_d != S_IDLE) && (state_d != S_HALT);
            halted_q <= (state_d == S_HALT);
            flag_q   <= flag_i;
            sp_q     <= sp_d;
            lstart_q <= lstart_d;
            lcnt_q   <= lcnt_d;
        end
    end

    assign instruction_o     = instr_q;
    assign init_inst_pulse_o = pulse_q;
    assign pc_o              = pc_q;
    assign busy_o            = busy_q;
    assign halted_o          = halted_q;
    assign error_o           = error_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inst_sequencer
//   Self-checking bench for inst_sequencer. A table of per-cycle vectors covers
//   the plain three-instruction program; hand-written sequences cover loops,
//   stack errors, jump/wrap, held flag, forced issue and reset mid-wait.
// -----------------------------------------------------------------------------
module tb_inst_sequencer;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic [9:0]   start_pc_i;
    logic         flag_i;
    logic         force_inst_i;
    logic         imem_wen_i;
    logic [9:0]   imem_waddr_i;
    logic [127:0] imem_wdata_i;
    logic [127:0] instruction_o;
    logic         init_inst_pulse_o;
    logic [9:0]   pc_o;
    logic         busy_o;
    logic         halted_o;
    logic         error_o;

    int checks = 0;
    int errors = 0;

    inst_sequencer dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .start_i           (start_i),
        .start_pc_i        (start_pc_i),
        .flag_i            (flag_i),
        .force_inst_i      (force_inst_i),
        .imem_wen_i        (imem_wen_i),
        .imem_waddr_i      (imem_waddr_i),
        .imem_wdata_i      (imem_wdata_i),
        .instruction_o     (instruction_o),
        .init_inst_pulse_o (init_inst_pulse_o),
        .pc_o              (pc_o),
        .busy_o            (busy_o),
        .halted_o          (halted_o),
        .error_o           (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic         frc;
        logic         flag;
        logic         exp_pulse;
        logic [9:0]   exp_pc;
        logic         exp_busy;
        logic         exp_halted;
        logic [127:0] exp_instr;
    } vec_t;

    vec_t         vec_q[$];
    logic [127:0] issued_q[$];

    function automatic logic [127:0] mk(input logic [7:0] op, input logic [15:0] arg);
        return {op, 104'h0, arg};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic row(input logic s, input logic f, input logic fl, input logic p,
                       input logic [9:0] pc, input logic b, input logic h, input logic [127:0] ins);
        vec_t v;
        v.start = s; v.frc = f; v.flag = fl; v.exp_pulse = p; v.exp_pc = pc;
        v.exp_busy = b; v.exp_halted = h; v.exp_instr = ins;
        vec_q.push_back(v);
    endtask

    task automatic write_mem(input logic [9:0] a, input logic [127:0] d);
        imem_wen_i = 1'b1; imem_waddr_i = a; imem_wdata_i = d;
        @(negedge clk);
        imem_wen_i = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] a);
        start_i = 1'b1; start_pc_i = a;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output logic seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (init_inst_pulse_o) seen = 1'b1;
        end
    endtask

    // Runs until HALT, answering every pulse with a one-cycle flag 3 cycles later.
    task automatic run_prog(input int budget, output int npulse, output logic done);
        int wcnt;
        npulse = 0; wcnt = 0; done = 1'b0;
        issued_q.delete();
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            flag_i = 1'b0;
            if (init_inst_pulse_o) begin
                npulse++;
                issued_q.push_back(instruction_o);
                wcnt = 3;
            end else if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) flag_i = 1'b1;
            end
            if (halted_o) done = 1'b1;
        end
        flag_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] i0, i1, i2, fx, opa, opb, garb;
        logic [127:0] first_s, second_s;
        logic seen, done;
        int   np, extra;

        i0   = mk(8'h11, 16'h0001);
        i1   = mk(8'h12, 16'h0002);
        i2   = mk(8'h13, 16'h0003);
        fx   = mk(8'h5A, 16'hBEEF);
        opa  = mk(8'h21, 16'hAAAA);
        opb  = mk(8'h22, 16'hBBBB);
        garb = mk(8'h33, 16'h3333);

        // Plain program: start (with force also high) at pc 0, flag 5 cycles after each pulse.
        row(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, fx);
        row(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, fx);
        row(1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, i0);
        for (int k = 0; k < 4; k++) row(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, i0);
        row(1'b0, 1'b0, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, i0);
        row(1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 1'b1, 1'b0, i0);
        row(1'b0, 1'b0, 1'b0, 1'b1, 10'd1, 1'b1, 1'b0, i1);
        for (int k = 0; k < 4; k++) row(1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 1'b1, 1'b0, i1);
        row(1'b0, 1'b0, 1'b1, 1'b0, 10'd2, 1'b1, 1'b0, i1);
        row(1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 1'b1, 1'b0, i1);
        row(1'b0, 1'b0, 1'b0, 1'b1, 10'd2, 1'b1, 1'b0, i2);
        for (int k = 0; k < 4; k++) row(1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 1'b1, 1'b0, i2);
        row(1'b0, 1'b0, 1'b1, 1'b0, 10'd3, 1'b1, 1'b0, i2);
        row(1'b0, 1'b0, 1'b0, 1'b0, 10'd3, 1'b1, 1'b0, i2);
        row(1'b0, 1'b0, 1'b0, 1'b0, 10'd3, 1'b0, 1'b1, i2);

        reset_i = 1'b1; start_i = 1'b0; start_pc_i = 10'd0; flag_i = 1'b0;
        force_inst_i = 1'b0; imem_wen_i = 1'b0; imem_waddr_i = 10'd0; imem_wdata_i = 128'h0;
        repeat (2) @(negedge clk);
        check("reset instruction", instruction_o, 128'h0);
        check("reset pulse", {127'h0, init_inst_pulse_o}, 128'h0);
        check("reset pc", {118'h0, pc_o}, 128'h0);
        check("reset busy", {127'h0, busy_o}, 128'h0);
        check("reset halted", {127'h0, halted_o}, 128'h0);
        check("reset error", {127'h0, error_o}, 128'h0);
        reset_i = 1'b0;
        @(negedge clk);

        // Forced issue from IDLE.
        force_inst_i = 1'b1; imem_wdata_i = fx;
        @(negedge clk);
        force_inst_i = 1'b0; imem_wdata_i = 128'h0;
        check("force pulse", {127'h0, init_inst_pulse_o}, 128'h1);
        check("force instruction", instruction_o, fx);
        check("force busy", {127'h0, busy_o}, 128'h1);
        @(negedge clk);
        check("force pulse one cycle", {127'h0, init_inst_pulse_o}, 128'h0);
        flag_i = 1'b1;
        @(negedge clk);
        flag_i = 1'b0;
        check("force back to idle", {126'h0, busy_o, halted_o}, 128'h0);
        check("force pc unchanged", {118'h0, pc_o}, 128'h0);

        // Test 1: table-driven plain program.
        write_mem(10'd0, i0);
        write_mem(10'd1, i1);
        write_mem(10'd2, i2);
        write_mem(10'd3, mk(8'hFF, 16'h0));
        start_pc_i = 10'd0;
        for (int i = 0; i < vec_q.size(); i++) begin
            start_i = vec_q[i].start; force_inst_i = vec_q[i].frc; flag_i = vec_q[i].flag;
            @(negedge clk);
            check($sformatf("t1[%0d] pulse", i), {127'h0, init_inst_pulse_o}, {127'h0, vec_q[i].exp_pulse});
            check($sformatf("t1[%0d] pc", i), {118'h0, pc_o}, {118'h0, vec_q[i].exp_pc});
            check($sformatf("t1[%0d] busy", i), {127'h0, busy_o}, {127'h0, vec_q[i].exp_busy});
            check($sformatf("t1[%0d] halted", i), {127'h0, halted_o}, {127'h0, vec_q[i].exp_halted});
            check($sformatf("t1[%0d] instruction", i), instruction_o, vec_q[i].exp_instr);
        end
        start_i = 1'b0; flag_i = 1'b0;

        // Force is ignored in HALT.
        force_inst_i = 1'b1; imem_wdata_i = fx;
        @(negedge clk);
        force_inst_i = 1'b0;
        check("halt force no pulse", {127'h0, init_inst_pulse_o}, 128'h0);
        check("halt force instruction", instruction_o, i2);
        check("halt force still halted", {127'h0, halted_o}, 128'h1);

        // Test 3a: five nested LOOPs overflow a 4-deep stack.
        for (int a = 0; a < 5; a++) write_mem(10'(a), mk(8'hF0, 16'd2));
        write_mem(10'd5, opa);
        write_mem(10'd6, mk(8'hFF, 16'h0));
        do_start(10'd0);
        run_prog(80, np, done);
        check("t3 overflow halted", {127'h0, done}, 128'h1);
        check("t3 overflow error", {127'h0, error_o}, 128'h1);
        check("t3 overflow pc", {118'h0, pc_o}, 128'd4);
        check("t3 overflow no pulse", 128'(np), 128'd0);

        // Test 3b: lone ENDL underflows; start first clears the sticky error.
        write_mem(10'h020, mk(8'hF1, 16'h0));
        do_start(10'h020);
        check("t3 start clears error", {127'h0, error_o}, 128'h0);
        run_prog(40, np, done);
        check("t3 underflow halted", {127'h0, done}, 128'h1);
        check("t3 underflow error", {127'h0, error_o}, 128'h1);
        check("t3 underflow pc", {118'h0, pc_o}, 128'h20);

        // Test 2: LOOP 3 { LOOP 2 { OPA } } HALT -> six OPA issues.
        write_mem(10'd0, mk(8'hF0, 16'd3));
        write_mem(10'd1, mk(8'hF0, 16'd2));
        write_mem(10'd2, opa);
        write_mem(10'd3, mk(8'hF1, 16'h0));
        write_mem(10'd4, mk(8'hF1, 16'h0));
        write_mem(10'd5, mk(8'hFF, 16'h0));
        do_start(10'd0);
        run_prog(400, np, done);
        check("t2 halted", {127'h0, done}, 128'h1);
        check("t2 pulse count", 128'(np), 128'd6);
        extra = 0;
        foreach (issued_q[k]) if (issued_q[k] !== opa) extra++;
        check("t2 all issues are OPA", 128'(extra), 128'd0);
        check("t2 error", {127'h0, error_o}, 128'h0);
        check("t2 pc", {118'h0, pc_o}, 128'd5);

        // Test 4: JUMP to the top address, then wrap to 0 after the flag.
        write_mem(10'h010, mk(8'hF2, 16'h03FF));
        write_mem(10'h3FF, opb);
        write_mem(10'd0, mk(8'hFF, 16'h0));
        do_start(10'h010);
        run_prog(100, np, done);
        check("t4 halted", {127'h0, done}, 128'h1);
        check("t4 pulse count", 128'(np), 128'd1);
        first_s = (issued_q.size() > 0) ? issued_q[0] : 128'h0;
        check("t4 issued OPB", first_s, opb);
        check("t4 pc wrapped", {118'h0, pc_o}, 128'd0);
        check("t4 error", {127'h0, error_o}, 128'h0);

        // Test 5: flag held high across the issue does not advance.
        write_mem(10'd0, opa);
        write_mem(10'd1, mk(8'hFF, 16'h0));
        flag_i = 1'b1;
        do_start(10'd0);
        wait_pulse(10, seen);
        check("t5 pulse seen", {127'h0, seen}, 128'h1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (init_inst_pulse_o) extra++;
        end
        check("t5 held flag pc", {118'h0, pc_o}, 128'd0);
        check("t5 held flag busy", {127'h0, busy_o}, 128'h1);
        check("t5 held flag no pulse", 128'(extra), 128'd0);
        flag_i = 1'b0;
        @(negedge clk);
        flag_i = 1'b1;
        @(negedge clk);
        flag_i = 1'b0;
        check("t5 advance pc", {118'h0, pc_o}, 128'd1);
        repeat (2) @(negedge clk);
        check("t5 halted", {127'h0, halted_o}, 128'h1);
        check("t5 halt pc", {118'h0, pc_o}, 128'd1);

        // Test 6: reset in WAIT; a write attempted while busy must not land.
        write_mem(10'd0, opa);
        write_mem(10'd1, opb);
        write_mem(10'd2, mk(8'hFF, 16'h0));
        do_start(10'd0);
        wait_pulse(10, seen);
        check("t6 pulse seen", {127'h0, seen}, 128'h1);
        write_mem(10'd1, garb);
        reset_i = 1'b1;
        @(negedge clk);
        check("t6 reset instruction", instruction_o, 128'h0);
        check("t6 reset pulse", {127'h0, init_inst_pulse_o}, 128'h0);
        check("t6 reset pc", {118'h0, pc_o}, 128'h0);
        check("t6 reset busy", {127'h0, busy_o}, 128'h0);
        check("t6 reset halted", {127'h0, halted_o}, 128'h0);
        check("t6 reset error", {127'h0, error_o}, 128'h0);
        reset_i = 1'b0;
        @(negedge clk);
        do_start(10'd0);
        run_prog(100, np, done);
        check("t6 restart halted", {127'h0, done}, 128'h1);
        check("t6 restart pulse count", 128'(np), 128'd2);
        first_s  = (issued_q.size() > 0) ? issued_q[0] : 128'h0;
        second_s = (issued_q.size() > 1) ? issued_q[1] : 128'h0;
        check("t6 restart first", first_s, opa);
        check("t6 restart second", second_s, opb);
        check("t6 restart pc", {118'h0, pc_o}, 128'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
